// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit core.
// Owns PC, IR and the retired-instruction counter. It steps the core through
// FETCH/DECODE/EXEC/MEM/WB, using req/ack handshakes to the instruction and
// data memories. It supports free-run, single-step, halt and bus timeout.
// The optional breakpoint stop is built when SEQ_BREAKPOINT_EN is defined.
module multicycle_sequencer #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 9,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               step,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  input  logic               dec_mem_rd,
  input  logic               dec_mem_wr,
  input  logic               dec_reg_wr,
  input  logic               dec_halt,
  input  logic               take_branch,
  input  logic [PC_W-1:0]    offset,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               reg_we,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic               bp_hit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_next;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               step_prev_q;
  logic               step_edge;
  logic               go;
  logic               timeout_hit;
  logic               bp_stop;

  // Saturating increment for the retired counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next PC: a signed branch offset or +1. The result wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] p,
                                                 input logic br,
                                                 input logic signed [PC_W-1:0] off);
    return br ? (p + $unsigned(off)) : (p + PC_W'(1));
  endfunction

  assign step_edge   = step & ~step_prev_q;
  assign pc_next     = pc_advance(pc_q, br_q, offset);
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

`ifdef SEQ_BREAKPOINT_EN
  logic run_prev_q;
  logic bp_hit_q, bp_hit_d;

  // After a breakpoint stop, IDLE needs a fresh run edge or a step edge to leave.
  assign bp_stop = bp_en && (pc_next == bp_addr);
  assign go      = bp_hit_q ? ((run & ~run_prev_q) | step_edge) : (run | step_edge);
  assign bp_hit  = bp_hit_q;

  // Breakpoint flag: set on a WB stop and cleared when IDLE is left.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (state_q == S_WB && bp_stop)
      bp_hit_d = 1'b1;
    else if (state_q == S_IDLE && go)
      bp_hit_d = 1'b0;
  end

  // Run level history and the breakpoint flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_prev_q <= 1'b0;
      bp_hit_q   <= 1'b0;
    end else begin
      run_prev_q <= run;
      bp_hit_q   <= bp_hit_d;
    end
  end
`else
  assign bp_stop = 1'b0;
  assign go      = run | step_edge;
`endif

  // State register, with step history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= step;
    end
  end

  // Next-state logic. Any ack outside its request state falls through unused.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
                else if (timeout_hit) state_d = S_ERR;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (dec_halt) state_d = S_HALT;
                else if (dec_mem_rd || dec_mem_wr) state_d = S_MEM;
                else state_d = S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
                else if (timeout_hit) state_d = S_ERR;
      S_WB:     if (bp_stop) state_d = S_IDLE;
                else if (run) state_d = S_FETCH;
                else state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Wait counter: counts cycles in a request state and restarts on every state entry.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && (state_d == state_q))
      wait_d = wait_q + WAIT_W'(1);
  end

  // Next values for PC, IR, the sampled branch decision and the retired counter.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    br_d      = br_q;
    retired_d = retired_q;
    if (state_q == S_FETCH && imem_ack)
      instr_d = imem_rdata;
    if (state_q == S_EXEC)
      br_d = take_branch;
    if (state_q == S_WB) begin
      pc_d      = pc_next;
      retired_d = sat_inc(retired_q);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      instr_q   <= '0;
      br_q      <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      br_q      <= br_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && dec_mem_wr;
    reg_we   = (state_q == S_WB) && dec_reg_wr;
    halted   = (state_q == S_HALT);
    bus_err  = (state_q == S_ERR);
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer. It uses directed and randomized instruction
// streams, which are checked against an instruction-level reference model.
module tb_multicycle_sequencer;
  localparam int INSTR_W = 16;
  localparam int PC_W    = 9;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int RET_MAX = (1 << CNT_W) - 1;
  localparam int PC_MOD  = 1 << PC_W;

  logic               clk = 1'b0;
  logic               reset_n, run, step;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr, pc, offset;
  logic [INSTR_W-1:0] imem_rdata, instr;
  logic               dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_halt, take_branch;
  logic               dmem_req, dmem_we, dmem_ack, reg_we, halted, bus_err;
  logic [2:0]         state;
  logic [CNT_W-1:0]   retired;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dreq_cnt = 0;
  int rwe_cnt = 0;
  int m_pc = 0;
  int m_ret = 0;

  multicycle_sequencer #(.INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr), .dec_halt(dec_halt),
    .take_branch(take_branch), .offset(offset),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we),
    .state(state), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dmem_req) dreq_cnt <= dreq_cnt + 1;
    if (reg_we)   rwe_cnt  <= rwe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // The PC after retiring one instruction: a signed branch offset or +1, wrapped.
  function automatic int model_next_pc(input int p, input bit br, input logic [PC_W-1:0] off);
    int delta;
    delta = br ? (off[PC_W-1] ? int'(off) - PC_MOD : int'(off)) : 1;
    return (p + delta + PC_MOD) % PC_MOD;
  endfunction

  function automatic logic [PC_W-1:0] off_to(input int target);
    int d;
    d = (target - m_pc + PC_MOD) % PC_MOD;
    return d[PC_W-1:0];
  endfunction

  // Run one instruction. The task starts with the FSM in FETCH and ends one
  // cycle after its WB.
  task automatic do_instr(input logic [INSTR_W-1:0] ir, input int iw, input int dw,
                          input bit rd, input bit wr, input bit rw, input bit br,
                          input logic [PC_W-1:0] off, input bit keep_run, input bit step_exec);
    int t0, d0, r0, exp_cyc;
    bit mem;
    mem = rd | wr;
    t0 = cyc; d0 = dreq_cnt; r0 = rwe_cnt;
    chk("fetch_state", state, 1);
    chk("imem_addr", imem_addr, m_pc);
    for (int i = 0; i <= iw; i++) begin
      chk("imem_req_held", imem_req, 1);
      imem_ack   = (i == iw);
      imem_rdata = (i == iw) ? ir : INSTR_W'($urandom);
      dmem_ack   = 1'($urandom_range(0, 1));
      tick();
    end
    dmem_ack = 1'b0;
    dec_mem_rd = rd; dec_mem_wr = wr; dec_reg_wr = rw; dec_halt = 1'b0;
    take_branch = br; offset = off;
    imem_ack = 1'($urandom_range(0, 1));
    chk("decode_state", state, 2);
    chk("instr_reg", instr, ir);
    tick();
    chk("exec_state", state, 3);
    if (step_exec) step = 1'b1;
    tick();
    step = 1'b0;
    imem_ack = 1'b0;
    take_branch = ~br;
    if (mem) begin
      for (int i = 0; i <= dw; i++) begin
        chk("mem_state", state, 4);
        chk("dmem_we", dmem_we, wr);
        chk("reg_we_in_mem", reg_we, 0);
        dmem_ack = (i == dw);
        tick();
      end
      dmem_ack = 1'b0;
    end
    chk("wb_state", state, 5);
    chk("reg_we_wb", reg_we, rw);
    chk("dmem_req_wb", dmem_req, 0);
    run = keep_run;
    tick();
    m_pc  = model_next_pc(m_pc, br, off);
    m_ret = (m_ret < RET_MAX) ? m_ret + 1 : RET_MAX;
    exp_cyc = 4 + iw + (mem ? dw + 1 : 0);
    chk("pc_after_wb", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("reg_we_pulse_count", rwe_cnt - r0, rw);
    chk("dmem_req_cycles", dreq_cnt - d0, mem ? dw + 1 : 0);
    chk("instr_cycles", cyc - t0, exp_cyc);
    chk("next_state", state, keep_run ? 1 : 0);
  endtask

  initial begin
    int n;
    int r_start;
    reset_n = 1'b0; run = 1'b0; step = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_reg_wr = 1'b0; dec_halt = 1'b0;
    take_branch = 1'b0; offset = '0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_flags", {halted, bus_err, reg_we, dmem_we}, 0);
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_hold", state, 0);

    // Three zero-wait ALU instructions in free-run.
    run = 1'b1;
    tick();
    do_instr(16'h1111, 0, 0, 0, 0, 1, 0, '0, 1, 0);
    do_instr(16'h2222, 0, 0, 0, 0, 1, 0, '0, 1, 0);
    do_instr(16'h3333, 0, 0, 0, 0, 1, 0, '0, 0, 0);
    chk("three_retired", retired, 3);
    chk("three_pc", pc, 3);

    // Load with dmem_ack delayed three cycles.
    run = 1'b1;
    tick();
    do_instr(16'h4444, 0, 3, 1, 0, 1, 0, '0, 1, 0);

    // Branch to 5, then take the -4 branch back to 1.
    do_instr(16'h5555, 1, 0, 0, 0, 0, 1, off_to(5), 1, 0);
    chk("pc_at_5", pc, 5);
    do_instr(16'h6666, 0, 0, 0, 0, 0, 1, 9'h1FC, 1, 0);
    chk("branch_back_pc", pc, 1);

    // Reach 0x1FF, then step with no branch so the PC wraps to 0.
    do_instr(16'h7777, 0, 0, 0, 0, 0, 1, off_to(9'h1FF), 1, 0);
    chk("pc_at_1ff", pc, 9'h1FF);
    do_instr(16'h8888, 2, 1, 0, 1, 0, 0, '0, 0, 0);
    chk("pc_wrap", pc, 0);

    // Single-step: three pulses, the second of them issued during EXEC.
    r_start = m_ret;
    step = 1'b1; tick(); step = 1'b0;
    do_instr(16'h9999, 0, 0, 0, 0, 1, 0, '0, 0, 1);
    repeat (3) tick();
    chk("step_park_idle", state, 0);
    step = 1'b1; tick(); step = 1'b0;
    do_instr(16'hAAAA, 1, 0, 0, 0, 1, 0, '0, 0, 0);
    repeat (3) tick();
    chk("step_two_retired", retired, r_start + 2);
    chk("step_idle_final", state, 0);

    // Randomized free-run stream. It is long enough for the retired counter to saturate.
    run = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      do_instr(INSTR_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), PC_W'($urandom), (i != 23), 0);
    end
    chk("retired_saturated", retired, RET_MAX);

    // Halt: terminal state that ignores acks; the counter and PC are unchanged.
    run = 1'b1;
    tick();
    chk("halt_fetch", state, 1);
    dec_halt = 1'b1; dec_reg_wr = 1'b1; dec_mem_rd = 1'b0; dec_mem_wr = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    tick();
    imem_ack = 1'b0;
    chk("halt_decode", state, 2);
    tick(); tick();
    chk("halt_state", state, 6);
    chk("halt_flag", halted, 1);
    chk("halt_retired", retired, m_ret);
    chk("halt_pc", pc, m_pc);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (4) tick();
    chk("halt_sticky", {state, halted}, {3'd6, 1'b1});
    chk("halt_no_req", {imem_req, dmem_req, dmem_we, reg_we}, 0);
    imem_ack = 1'b0; dmem_ack = 1'b0; dec_halt = 1'b0; dec_reg_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("halt_reset_async", {state, halted}, 0);
    m_pc = 0; m_ret = 0;
    tick();
    reset_n = 1'b1;

    // Fetch timeout: imem_ack is never returned.
    run = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 40 && state == 3'd1; i++) begin
      if (imem_req) n++;
      tick();
    end
    chk("timeout_fetch_cycles", n, TIMEOUT);
    chk("timeout_err_state", state, 7);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_req_dropped", imem_req, 0);
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    chk("err_sticky", {state, bus_err}, {3'd7, 1'b1});

    // Reset asserted mid-handshake takes effect without a clock edge.
    reset_n = 1'b0;
    #1;
    chk("err_reset_clear", bus_err, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("refetch_state", state, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midfetch_reset", {state, imem_req}, 0);
    chk("midfetch_pc", pc, 0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
